// File: rtl/mult_share_arbiter_if.sv
// mult_share_arbiter_if: request, multiplier and response signals of the shared-multiplier arbiter
interface mult_share_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int W = 4,
  parameter int ID_W = 2
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [2*W-1:0] mul_p;
  logic rsp_valid;
  logic rsp_ready;
  logic [2*W-1:0] rsp_data;
  logic [ID_W-1:0] rsp_id;
  logic busy;
  modport slave (
    input req_valid, req_a, req_b, mul_p, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );
  modport master (
    output req_valid, req_a, req_b, mul_p, rsp_ready,
    input req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one signed multiplier among N_REQ requesters
module mult_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int W = 4,
  parameter int ID_W = 2
) (
  input logic clk,
  input logic rst,
  mult_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_last, r_cur_id, r_rsp_id;
  logic [ID_W-1:0] w_grant, w_pick_hi, w_pick_lo;
  logic [W-1:0] r_op_a, r_op_b, w_a, w_b;
  logic [2*W-1:0] r_rsp_data;
  logic r_rsp_valid;
  logic w_hi_any, w_any, w_accept;
  logic [N_REQ-1:0] w_ready;
  // lowest valid index above the last grant wins, else wrap to lowest valid overall
  always_comb begin
    w_hi_any = 1'b0;
    w_pick_hi = '0;
    w_pick_lo = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) w_pick_lo = ID_W'(i);
      if (bus.req_valid[i] && i > int'(r_last)) begin
        w_pick_hi = ID_W'(i);
        w_hi_any = 1'b1;
      end
    end
    w_grant = w_hi_any ? w_pick_hi : w_pick_lo;
  end
  assign w_any = |bus.req_valid;
  assign w_accept = (r_state == IDLE) && w_any;
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant == ID_W'(i)) begin
        w_a = bus.req_a[i*W +: W];
        w_b = bus.req_b[i*W +: W];
        w_ready[i] = w_accept;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && w_any) w_next = CALC;
    else if (r_state == CALC) w_next = RESP;
    else if (r_state == RESP && bus.rsp_ready) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= ID_W'(N_REQ - 1);
      r_cur_id <= '0;
      r_op_a <= '0;
      r_op_b <= '0;
      r_rsp_data <= '0;
      r_rsp_id <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op_a <= w_a;
        r_op_b <= w_b;
        r_cur_id <= w_grant;
        r_last <= w_grant;
      end
      if (r_state == CALC) begin
        r_rsp_data <= bus.mul_p;
        r_rsp_id <= r_cur_id;
        r_rsp_valid <= 1'b1;
      end else if (r_state == RESP && bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end
  assign bus.req_ready = w_ready;
  assign bus.mul_a = r_op_a;
  assign bus.mul_b = r_op_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_id = r_rsp_id;
  assign bus.busy = (r_state != IDLE);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mult_share_arbiter;
  localparam int N_REQ = 4;
  localparam int W = 4;
  localparam int ID_W = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  mult_share_arbiter_if #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) bus ();
  mult_share_arbiter #(.N_REQ(N_REQ), .W(W), .ID_W(ID_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic signed [2*W-1:0] ext_a, ext_b;
  assign ext_a = {{W{bus.mul_a[W-1]}}, bus.mul_a};
  assign ext_b = {{W{bus.mul_b[W-1]}}, bus.mul_b};
  assign bus.mul_p = ext_a * ext_b;

  function automatic int exp_grant(logic [N_REQ-1:0] v, int last);
    for (int k = 1; k <= N_REQ; k++) if (v[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [2*W-1:0] prod(logic [W-1:0] a, logic [W-1:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[2*W-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, logic [W-1:0] a, logic [W-1:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.mul_a, bus.mul_b, bus.rsp_data, bus.rsp_id} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b ma=%h mb=%h data=%h id=%0d want all zero",
               bus.rsp_valid, bus.busy, bus.mul_a, bus.mul_b, bus.rsp_data, bus.rsp_id);
    end
    checks++;
    if (bus.req_ready !== '0) begin
      errors++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b1;
    set_req(2, 4'b1100, 4'b1101);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b want 0100", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    #1;
    checks++;
    if ({bus.req_ready, bus.busy, bus.rsp_valid} !== {4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_calc: got ready=%b busy=%b valid=%b want 0000 1 0", bus.req_ready, bus.busy, bus.rsp_valid);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 8'h0C, 2'd2}) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b data=%h id=%0d want 1 0c 2", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL single_retire: got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] ta [6] = '{4'b0011, 4'b1000, 4'b1111, 4'b1000, 4'b0110, 4'b1101};
    logic [W-1:0] tb [6] = '{4'b1111, 4'b0111, 4'b1111, 4'b1011, 4'b0101, 4'b0000};
    logic [2*W-1:0] tp [6] = '{8'hFD, 8'hC8, 8'h01, 8'h28, 8'h1E, 8'h00};
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(0, ta[k], tb[k]);
      #1;
      checks++;
      if (bus.req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL signed_grant[%0d]: got %b want 0001", k, bus.req_ready);
      end
      tick();
      bus.req_valid = '0;
      tick();
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, tp[k], 2'd0}) begin
        errors++;
        $display("FAIL signed_rsp[%0d]: got valid=%b data=%h id=%0d want 1 %h 0", k, bus.rsp_valid, bus.rsp_data, bus.rsp_id, tp[k]);
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    logic [W-1:0] a [N_REQ];
    logic [W-1:0] b [N_REQ];
    int last = N_REQ - 1;
    int e;
    test_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      a[i] = W'($urandom);
      b[i] = W'($urandom);
      set_req(i, a[i], b[i]);
    end
    for (int k = 0; k < 6; k++) begin
      #1;
      e = exp_grant(bus.req_valid, last);
      checks++;
      if (bus.req_ready !== N_REQ'(1 << e) || e != k % N_REQ) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b want %b (requester %0d)", k, bus.req_ready, N_REQ'(1 << (k % N_REQ)), k % N_REQ);
      end
      tick();
      checks++;
      if (bus.req_ready !== '0) begin
        errors++;
        $display("FAIL rr_calc_ready[%0d]: got %b want 0000", k, bus.req_ready);
      end
      tick();
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {4'b0000, 1'b1, prod(a[e], b[e]), ID_W'(e)}) begin
        errors++;
        $display("FAIL rr_rsp[%0d]: got ready=%b valid=%b data=%h id=%0d want 0000 1 %h %0d",
                 k, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id, prod(a[e], b[e]), e);
      end
      last = e;
      tick();
    end
    bus.req_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a3, b3, a0, b0;
    a3 = W'($urandom);
    b3 = W'($urandom);
    a0 = W'($urandom);
    b0 = W'($urandom);
    bus.rsp_ready = 1'b0;
    set_req(3, a3, b3);
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant: got %b want 1000", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    set_req(0, a0, b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {4'b0000, 1'b1, prod(a3, b3), 2'd3}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b data=%h id=%0d want 0000 1 %h 3",
                 k, bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_id, prod(a3, b3));
      end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== {1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL bp_retire_cycle: got valid=%b ready=%b want 1 0000", bus.rsp_valid, bus.req_ready);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.busy, bus.req_ready} !== {1'b0, 1'b0, 4'b0001}) begin
      errors++;
      $display("FAIL bp_after: got valid=%b busy=%b ready=%b want 0 0 0001", bus.rsp_valid, bus.busy, bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, prod(a0, b0), 2'd0}) begin
      errors++;
      $display("FAIL bp_next_rsp: got valid=%b data=%h id=%0d want 1 %h 0", bus.rsp_valid, bus.rsp_data, bus.rsp_id, prod(a0, b0));
    end
    tick();
  endtask

  task automatic test_operand_change();
    bus.rsp_ready = 1'b1;
    set_req(1, 4'b0101, 4'b0111);
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL opchg_grant: got %b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    bus.req_a[1*W +: W] = 4'b1111;
    bus.req_b[1*W +: W] = 4'b0001;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, 8'h23, 2'd1}) begin
      errors++;
      $display("FAIL opchg_rsp: got valid=%b data=%h id=%0d want 1 23 1", bus.rsp_valid, bus.rsp_data, bus.rsp_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a1, b1;
    a1 = W'($urandom);
    b1 = W'($urandom);
    bus.rsp_ready = 1'b1;
    set_req(2, 4'b0111, 4'b0111);
    tick();
    bus.req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      errors++;
      $display("FAIL rstmid_state: got valid=%b busy=%b want 0 0", bus.rsp_valid, bus.busy);
    end
    set_req(1, a1, b1);
    set_req(2, W'($urandom), W'($urandom));
    set_req(3, W'($urandom), W'($urandom));
    #1;
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rstmid_grant: got %b want 0010", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_stale: got valid=%b want 0", bus.rsp_valid);
    end
    tick();
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_id} !== {1'b1, prod(a1, b1), 2'd1}) begin
      errors++;
      $display("FAIL rstmid_rsp: got valid=%b data=%h id=%0d want 1 %h 1", bus.rsp_valid, bus.rsp_data, bus.rsp_id, prod(a1, b1));
    end
    tick();
  endtask

  task automatic test_random();
    int last = N_REQ - 1;
    bit pend = 1'b0;
    int age = 0;
    logic [2*W-1:0] ed = '0;
    int eid = 0;
    int waits [N_REQ];
    int e;
    logic [N_REQ-1:0] er;
    test_reset();
    for (int i = 0; i < N_REQ; i++) waits[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_valid[i]) begin
          bus.req_a[i*W +: W] = W'($urandom);
          bus.req_b[i*W +: W] = W'($urandom);
          if ($urandom_range(0, 2) == 0) bus.req_valid[i] = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      e = pend ? -1 : exp_grant(bus.req_valid, last);
      er = (e < 0) ? '0 : N_REQ'(1 << e);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.busy} !== {er, pend && age >= 1, pend}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got ready=%b valid=%b busy=%b want %b %b %b",
                 c, bus.req_ready, bus.rsp_valid, bus.busy, er, pend && age >= 1, pend);
      end
      if (pend && age >= 1) begin
        checks++;
        if ({bus.rsp_data, bus.rsp_id} !== {ed, ID_W'(eid)}) begin
          errors++;
          $display("FAIL rand_rsp[%0d]: got data=%h id=%0d want %h %0d", c, bus.rsp_data, bus.rsp_id, ed, eid);
        end
      end
      if (e >= 0) begin
        checks++;
        if (waits[e] > N_REQ - 1) begin
          errors++;
          $display("FAIL rand_fair[%0d]: requester %0d waited %0d grants want <= %0d", c, e, waits[e], N_REQ - 1);
        end
        for (int i = 0; i < N_REQ; i++) if (i != e && bus.req_valid[i]) waits[i]++;
        waits[e] = 0;
        pend = 1'b1;
        age = 0;
        ed = prod(bus.req_a[e*W +: W], bus.req_b[e*W +: W]);
        eid = e;
        last = e;
      end else if (pend) begin
        if (age >= 1 && bus.rsp_ready) pend = 1'b0;
        else age++;
      end
      tick();
      if (e >= 0) bus.req_valid[e] = 1'b0;
    end
    bus.req_valid = '0;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_signed();
    test_round_robin();
    test_backpressure();
    test_operand_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
